// File: rtl/cpu_trace_recorder.sv
// Per-cycle CPU trace capture into a show-ahead FIFO with valid/ready drain.
// Ports: clk_i/rst_i, start/clear/limit control, CPU taps, tr_* drain, status.
module cpu_trace_recorder #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  parameter int MODE    = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         clear_i,
  input  logic [CNT_W-1:0]             limit_i,
  input  logic [DATA_W-1:0]            pc_i,
  input  logic                         rf_we_i,
  input  logic [RADDR_W-1:0]           rf_waddr_i,
  input  logic [DATA_W-1:0]            rf_wdata_i,
  output logic                         tr_valid_o,
  input  logic                         tr_ready_i,
  output logic [CNT_W-1:0]             tr_cycle_o,
  output logic [DATA_W-1:0]            tr_pc_o,
  output logic                         tr_we_o,
  output logic [RADDR_W-1:0]           tr_waddr_o,
  output logic [DATA_W-1:0]            tr_wdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         running_o,
  output logic                         done_o,
  output logic                         overflow_o,
  output logic [CNT_W-1:0]             drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0]   cyc;
    logic [DATA_W-1:0]  pc;
    logic               we;
    logic [RADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  wdata;
  } ent_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] limit_q, limit_n;
  logic [CNT_W-1:0] cyc_q, cyc_n;

  ent_t             mem [DEPTH];
  ent_t             head;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic [CNT_W-1:0] drop_q;

  logic filt, cap, pop, full, push, drop;

  assign filt = (MODE == 1) ? (rf_we_i && (rf_waddr_i != '0)) : 1'b1;
  assign cap  = (state == RUN) && filt && !clear_i;
  assign full = (cnt_q == CW'(DEPTH));
  assign pop  = tr_valid_o && tr_ready_i && !clear_i;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  always_comb begin
    state_n = state;
    limit_n = limit_q;
    cyc_n   = cyc_q;
    if (clear_i) begin
      state_n = IDLE;
      cyc_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state_n = RUN;
            limit_n = limit_i;
            cyc_n   = '0;
          end
        end
        RUN: begin
          cyc_n = cyc_q + CNT_W'(1);
          if ((limit_q != '0) && (cyc_q == limit_q - CNT_W'(1)))
            state_n = DONE;
        end
        DONE: begin
          state_n = DONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      limit_q <= '0;
      cyc_q   <= '0;
    end else begin
      state   <= state_n;
      limit_q <= limit_n;
      cyc_q   <= cyc_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= '{cyc_q, pc_i, rf_we_i, rf_waddr_i, rf_wdata_i};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        cnt_q <= cnt_q + CW'(1);
      else if (pop && !push)
        cnt_q <= cnt_q - CW'(1);
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  // Head fields are forced to zero when empty so reset leaves all outputs 0.
  assign tr_valid_o = (cnt_q != '0);
  assign head       = tr_valid_o ? mem[rd_ptr] : '0;
  assign tr_cycle_o = head.cyc;
  assign tr_pc_o    = head.pc;
  assign tr_we_o    = head.we;
  assign tr_waddr_o = head.waddr;
  assign tr_wdata_o = head.wdata;
  assign count_o    = cnt_q;
  assign running_o  = (state == RUN);
  assign done_o     = (state == DONE);
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_cpu_trace_recorder.sv
// Directed bench for cpu_trace_recorder: three instances cover MODE/DEPTH.
// u0: MODE0 DEPTH32, u1: MODE1 DEPTH16, u2: MODE0 DEPTH4.
module tb_cpu_trace_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] lim = '0;
  logic [31:0] pc = '0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
  logic        rd0 = 1'b0, rd1 = 1'b0, rd2 = 1'b0;

  logic        v0, v1, v2;
  logic [15:0] cy0, cy1, cy2;
  logic [31:0] pc0, pc1, pc2;
  logic        we0, we1, we2;
  logic [4:0]  wa0, wa1, wa2;
  logic [31:0] wd0, wd1, wd2;
  logic [5:0]  cn0;
  logic [4:0]  cn1;
  logic [2:0]  cn2;
  logic        ru0, ru1, ru2;
  logic        dn0, dn1, dn2;
  logic        ov0, ov1, ov2;
  logic [15:0] dc0, dc1, dc2;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cpu_trace_recorder #(.DEPTH(32), .MODE(0)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(st0), .clear_i(clr),
    .limit_i(lim), .pc_i(pc), .rf_we_i(we), .rf_waddr_i(wa),
    .rf_wdata_i(wd), .tr_valid_o(v0), .tr_ready_i(rd0),
    .tr_cycle_o(cy0), .tr_pc_o(pc0), .tr_we_o(we0),
    .tr_waddr_o(wa0), .tr_wdata_o(wd0), .count_o(cn0),
    .running_o(ru0), .done_o(dn0), .overflow_o(ov0),
    .drop_cnt_o(dc0));

  cpu_trace_recorder #(.DEPTH(16), .MODE(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(st1), .clear_i(clr),
    .limit_i(lim), .pc_i(pc), .rf_we_i(we), .rf_waddr_i(wa),
    .rf_wdata_i(wd), .tr_valid_o(v1), .tr_ready_i(rd1),
    .tr_cycle_o(cy1), .tr_pc_o(pc1), .tr_we_o(we1),
    .tr_waddr_o(wa1), .tr_wdata_o(wd1), .count_o(cn1),
    .running_o(ru1), .done_o(dn1), .overflow_o(ov1),
    .drop_cnt_o(dc1));

  cpu_trace_recorder #(.DEPTH(4), .MODE(0)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(st2), .clear_i(clr),
    .limit_i(lim), .pc_i(pc), .rf_we_i(we), .rf_waddr_i(wa),
    .rf_wdata_i(wd), .tr_valid_o(v2), .tr_ready_i(rd2),
    .tr_cycle_o(cy2), .tr_pc_o(pc2), .tr_we_o(we2),
    .tr_waddr_o(wa2), .tr_wdata_o(wd2), .count_o(cn2),
    .running_o(ru2), .done_o(dn2), .overflow_o(ov2),
    .drop_cnt_o(dc2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #3;
    check("rst_v0", v0, 0);
    check("rst_cn0", cn0, 0);
    check("rst_ru0", ru0, 0);
    check("rst_dn0", dn0, 0);
    check("rst_ov0", ov0, 0);
    check("rst_dc0", dc0, 0);
    check("rst_pc0", pc0, 0);
    check("rst_cy2", cy2, 0);
    tick();
    rst = 1'b1;
    tick();

    // 1: 30-cycle full dump, drained every cycle
    lim = 16'd30;
    rd0 = 1'b1;
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    check("t1_run", ru0, 1);
    for (int i = 0; i < 30; i++) begin
      pc = 32'(4 * i);
      tick();
      check("t1_v", v0, 1);
      check("t1_cyc", cy0, 64'(i));
      check("t1_pc", pc0, 64'(4 * i));
      check("t1_done", dn0, (i == 29) ? 1 : 0);
    end
    tick();
    check("t1_empty", v0, 0);
    check("t1_ovf", ov0, 0);
    check("t1_drop", dc0, 0);

    // 2: write filter, r0 suppressed
    lim = 16'd10;
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      pc = 32'(4 * c);
      we = (c == 2 || c == 5 || c == 7);
      wa = (c == 2) ? 5'd8 : (c == 5) ? 5'd0 : 5'd9;
      wd = 32'(100 + c);
      tick();
    end
    we = 1'b0;
    check("t2_done", dn1, 1);
    check("t2_cnt", cn1, 2);
    check("t2_cyc_a", cy1, 2);
    check("t2_wa_a", wa1, 8);
    check("t2_wd_a", wd1, 102);
    check("t2_we_a", we1, 1);
    rd1 = 1'b1;
    tick();
    check("t2_cyc_b", cy1, 7);
    check("t2_wa_b", wa1, 9);
    check("t2_pc_b", pc1, 28);
    tick();
    check("t2_empty", v1, 0);

    // 3: DEPTH 4 stalled, overflow then ordered drain
    lim = 16'd10;
    rd2 = 1'b0;
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      pc = 32'(4 * c);
      tick();
    end
    check("t3_cnt", cn2, 4);
    check("t3_ovf", ov2, 1);
    check("t3_drop", dc2, 6);
    check("t3_done", dn2, 1);
    rd2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t3_cyc", cy2, 64'(c));
      check("t3_pc", pc2, 64'(4 * c));
      tick();
    end
    check("t3_empty", v2, 0);
    check("t3_cnt0", cn2, 0);

    // 4: full with concurrent pop keeps level, no drops
    clr = 1'b1;
    tick();
    clr = 1'b0;
    lim = 16'd0;
    rd2 = 1'b0;
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("t4_full", cn2, 4);
    rd2 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t4_cnt", cn2, 4);
      check("t4_cyc", cy2, 64'(k));
      check("t4_drop", dc2, 0);
    end
    check("t4_ovf", ov2, 0);

    // 6: clear in DONE with data and overflow
    clr = 1'b1;
    tick();
    clr = 1'b0;
    lim = 16'd6;
    rd2 = 1'b0;
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check("t6_done", dn2, 1);
    check("t6_ovf", ov2, 1);
    check("t6_drop", dc2, 2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t6_v", v2, 0);
    check("t6_cnt", cn2, 0);
    check("t6_ovf0", ov2, 0);
    check("t6_drop0", dc2, 0);
    check("t6_idle_d", dn2, 0);
    check("t6_idle_r", ru2, 0);

    // 5: async reset mid-RUN
    lim = 16'd0;
    rd2 = 1'b0;
    st2 = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) tick();
    check("t5_cnt3", cn2, 3);
    #2;
    rst = 1'b0;
    #1;
    check("t5_v", v2, 0);
    check("t5_cnt", cn2, 0);
    check("t5_run", ru2, 0);
    check("t5_cyc", cy2, 0);
    rst = 1'b1;
    pc = 32'h40;
    tick();
    check("t5_rerun", ru2, 1);
    tick();
    st2 = 1'b0;
    check("t5_v1", v2, 1);
    check("t5_cyc0", cy2, 0);
    check("t5_pc", pc2, 64'h40);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
